// File: rtl/sha256_axil_pkg.sv
// Shared definitions for the SHA-256 AXI4-lite register slave: offsets, bit positions, FSM states.
// The optional interrupt output is enabled by defining SHA256_AXIL_IRQ_EN.
package sha256_axil_pkg;

  localparam logic [7:0] CTRL_OFF    = 8'h00;
  localparam logic [7:0] STATUS_OFF  = 8'h04;
  localparam logic [7:0] MSG_BASE    = 8'h40;
  localparam logic [7:0] DIGEST_BASE = 8'h80;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_INIT_BIT   = 1;
  localparam int CTRL_IE_BIT     = 2;
  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;
  typedef enum logic [2:0] {REG_CTRL, REG_STATUS, REG_MSG, REG_DIGEST, REG_NONE} reg_sel_e;

  // Classifies a word offset (byte offset bits [7:2]) into a register region.
  function automatic reg_sel_e reg_decode(input logic [5:0] word_off);
    if (word_off == CTRL_OFF[7:2])                 return REG_CTRL;
    else if (word_off == STATUS_OFF[7:2])          return REG_STATUS;
    else if (word_off[5:4] == MSG_BASE[7:6])       return REG_MSG;
    else if (word_off[5:3] == DIGEST_BASE[7:5])    return REG_DIGEST;
    else                                           return REG_NONE;
  endfunction

endpackage

// File: rtl/sha256_axil_if.sv
// AXI4-lite channel handshake engine: independent AW/W capture, one outstanding write,
// single-beat registered reads. Presents a simple wr_en / rd_en register-file port.
module sha256_axil_if
  import sha256_axil_pkg::*;
#(
  parameter int ADDR_LSB_W = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  mem_axi_awvalid,
  output logic                  mem_axi_awready,
  input  logic [31:0]           mem_axi_awaddr,
  input  logic [2:0]            mem_axi_awprot,
  input  logic                  mem_axi_wvalid,
  output logic                  mem_axi_wready,
  input  logic [31:0]           mem_axi_wdata,
  input  logic [3:0]            mem_axi_wstrb,
  output logic                  mem_axi_bvalid,
  input  logic                  mem_axi_bready,
  input  logic                  mem_axi_arvalid,
  output logic                  mem_axi_arready,
  input  logic [31:0]           mem_axi_araddr,
  input  logic [2:0]            mem_axi_arprot,
  output logic                  mem_axi_rvalid,
  input  logic                  mem_axi_rready,
  output logic [31:0]           mem_axi_rdata,
  output logic                  wr_en,
  output logic [ADDR_LSB_W-1:0] wr_addr,
  output logic [31:0]           wr_data,
  output logic [3:0]            wr_strb,
  output logic                  rd_en,
  output logic [ADDR_LSB_W-1:0] rd_addr,
  input  logic [31:0]           rd_data
);

  w_state_e              r_wstate;
  r_state_e              r_rstate;
  logic                  r_awready, r_wready, r_bvalid;
  logic                  r_arready, r_rvalid;
  logic [ADDR_LSB_W-1:0] r_awaddr;
  logic [31:0]           r_wdata, r_rdata;
  logic [3:0]            r_wstrb;
  logic                  w_wr_en, w_rd_en;
  logic                  w_unused;

  // A dropped ready means that channel's beat is already held.
  assign w_wr_en = (r_wstate == W_WAIT) && !r_awready && !r_wready;
  assign w_rd_en = r_arready && mem_axi_arvalid;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_bvalid  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      unique case (r_wstate)
        W_IDLE, W_WAIT: begin
          if (mem_axi_awvalid && r_awready) begin
            r_awaddr  <= mem_axi_awaddr[ADDR_LSB_W-1:0];
            r_awready <= 1'b0;
            r_wstate  <= W_WAIT;
          end
          if (mem_axi_wvalid && r_wready) begin
            r_wdata  <= mem_axi_wdata;
            r_wstrb  <= mem_axi_wstrb;
            r_wready <= 1'b0;
            r_wstate <= W_WAIT;
          end
          if (w_wr_en) begin
            r_wstate <= W_RESP;
            r_bvalid <= 1'b1;
          end
        end
        W_RESP: begin
          if (mem_axi_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      unique case (r_rstate)
        R_IDLE: begin
          if (w_rd_en) begin
            r_rdata   <= rd_data;
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
            r_rstate  <= R_DATA;
          end
        end
        R_DATA: begin
          if (mem_axi_rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign mem_axi_awready = r_awready;
  assign mem_axi_wready  = r_wready;
  assign mem_axi_bvalid  = r_bvalid;
  assign mem_axi_arready = r_arready;
  assign mem_axi_rvalid  = r_rvalid;
  assign mem_axi_rdata   = r_rdata;

  assign wr_en   = w_wr_en;
  assign wr_addr = r_awaddr;
  assign wr_data = r_wdata;
  assign wr_strb = r_wstrb;
  assign rd_en   = w_rd_en;
  assign rd_addr = mem_axi_araddr[ADDR_LSB_W-1:0];

  assign w_unused = &{1'b0, mem_axi_awprot, mem_axi_arprot,
                      mem_axi_awaddr[31:ADDR_LSB_W], mem_axi_araddr[31:ADDR_LSB_W]};

endmodule

// File: rtl/sha256_axil_slave.sv
// AXI4-lite register front-end for the SHA-256 core: CTRL/STATUS, 16-word MSG buffer, 8-word DIGEST.
// Define SHA256_AXIL_IRQ_EN to add the irq output and the CTRL.IE bit.
module sha256_axil_slave
  import sha256_axil_pkg::*;
#(
  parameter int         ADDR_LSB_W = 8,
  parameter logic [1:0] RESP_OKAY  = 2'b00
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          mem_axi_awvalid,
  output logic          mem_axi_awready,
  input  logic [31:0]   mem_axi_awaddr,
  input  logic [2:0]    mem_axi_awprot,
  input  logic          mem_axi_wvalid,
  output logic          mem_axi_wready,
  input  logic [31:0]   mem_axi_wdata,
  input  logic [3:0]    mem_axi_wstrb,
  output logic          mem_axi_bvalid,
  input  logic          mem_axi_bready,
  input  logic          mem_axi_arvalid,
  output logic          mem_axi_arready,
  input  logic [31:0]   mem_axi_araddr,
  input  logic [2:0]    mem_axi_arprot,
  output logic          mem_axi_rvalid,
  input  logic          mem_axi_rready,
  output logic [31:0]   mem_axi_rdata,
  output logic          core_start,
  output logic          core_init,
  output logic [511:0]  core_block,
  input  logic          core_busy,
  input  logic          core_digest_valid,
`ifdef SHA256_AXIL_IRQ_EN
  output logic          irq,
`endif
  input  logic [255:0]  core_digest
);

  logic                  w_wr_en, w_rd_en;
  logic [ADDR_LSB_W-1:0] w_wr_addr, w_rd_addr;
  logic [31:0]           w_wr_data, w_rd_data;
  logic [3:0]            w_wr_strb;
  reg_sel_e              w_wr_sel, w_rd_sel;
  logic [5:0]            w_wr_woff, w_rd_woff;
  logic                  w_ctrl_wr, w_start_fire, w_msg_wr;
  logic                  w_unused;

  logic [31:0] r_msg    [16];
  logic [31:0] r_digest [8];
  logic        r_init, r_done, r_core_start, r_start_pend;

  sha256_axil_if #(.ADDR_LSB_W(ADDR_LSB_W)) u_if (
    .clk             (clk),
    .resetn          (resetn),
    .mem_axi_awvalid (mem_axi_awvalid),
    .mem_axi_awready (mem_axi_awready),
    .mem_axi_awaddr  (mem_axi_awaddr),
    .mem_axi_awprot  (mem_axi_awprot),
    .mem_axi_wvalid  (mem_axi_wvalid),
    .mem_axi_wready  (mem_axi_wready),
    .mem_axi_wdata   (mem_axi_wdata),
    .mem_axi_wstrb   (mem_axi_wstrb),
    .mem_axi_bvalid  (mem_axi_bvalid),
    .mem_axi_bready  (mem_axi_bready),
    .mem_axi_arvalid (mem_axi_arvalid),
    .mem_axi_arready (mem_axi_arready),
    .mem_axi_araddr  (mem_axi_araddr),
    .mem_axi_arprot  (mem_axi_arprot),
    .mem_axi_rvalid  (mem_axi_rvalid),
    .mem_axi_rready  (mem_axi_rready),
    .mem_axi_rdata   (mem_axi_rdata),
    .wr_en           (w_wr_en),
    .wr_addr         (w_wr_addr),
    .wr_data         (w_wr_data),
    .wr_strb         (w_wr_strb),
    .rd_en           (w_rd_en),
    .rd_addr         (w_rd_addr),
    .rd_data         (w_rd_data)
  );

  // Offsets with any decoded bit above the 8-bit register window map to nothing.
  assign w_wr_woff = w_wr_addr[7:2];
  assign w_rd_woff = w_rd_addr[7:2];
  assign w_wr_sel  = ((w_wr_addr >> 8) == '0) ? reg_decode(w_wr_woff) : REG_NONE;
  assign w_rd_sel  = ((w_rd_addr >> 8) == '0) ? reg_decode(w_rd_woff) : REG_NONE;

  // A start stays "pending" from acceptance until the core reports busy, so MSG cannot shift under it.
  assign w_ctrl_wr    = w_wr_en && (w_wr_sel == REG_CTRL) && w_wr_strb[0];
  assign w_start_fire = w_ctrl_wr && w_wr_data[CTRL_START_BIT] && !core_busy && !r_start_pend;
  assign w_msg_wr     = w_wr_en && (w_wr_sel == REG_MSG) && !core_busy && !r_start_pend;

  // NOTE: the message and digest arrays are reset explicitly because firmware may read them before any write.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 16; i++) r_msg[i] <= '0;
      for (int i = 0; i < 8; i++)  r_digest[i] <= '0;
      r_init       <= 1'b0;
      r_done       <= 1'b0;
      r_core_start <= 1'b0;
      r_start_pend <= 1'b0;
    end else begin
      r_core_start <= w_start_fire;
      if (core_busy || core_digest_valid) r_start_pend <= 1'b0;
      if (w_start_fire) r_start_pend <= 1'b1;
      if (w_ctrl_wr) r_init <= w_wr_data[CTRL_INIT_BIT];
      // Digest completion outranks a simultaneous START clear.
      if (w_start_fire) r_done <= 1'b0;
      if (core_digest_valid) begin
        r_done <= 1'b1;
        for (int i = 0; i < 8; i++) r_digest[i] <= core_digest[255-32*i -: 32];
      end
      if (w_msg_wr) begin
        for (int b = 0; b < 4; b++) begin
          if (w_wr_strb[b]) r_msg[w_wr_woff[3:0]][8*b +: 8] <= w_wr_data[8*b +: 8];
        end
      end
    end
  end

`ifdef SHA256_AXIL_IRQ_EN
  logic r_ie, r_irq;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ie  <= 1'b0;
      r_irq <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_ie <= w_wr_data[CTRL_IE_BIT];
      r_irq <= r_done && r_ie;
    end
  end

  assign irq = r_irq;
`endif

  // NOTE: every path through this block starts from a zero default, so no latch is inferred.
  always_comb begin
    w_rd_data = '0;
    unique case (w_rd_sel)
      REG_CTRL: begin
        w_rd_data[CTRL_INIT_BIT] = r_init;
`ifdef SHA256_AXIL_IRQ_EN
        w_rd_data[CTRL_IE_BIT] = r_ie;
`endif
      end
      REG_STATUS: begin
        w_rd_data[STATUS_BUSY_BIT] = core_busy;
        w_rd_data[STATUS_DONE_BIT] = r_done;
      end
      REG_MSG:    w_rd_data = r_msg[w_rd_woff[3:0]];
      REG_DIGEST: w_rd_data = r_digest[w_rd_woff[2:0]];
      default:    w_rd_data = '0;
    endcase
  end

  for (genvar g = 0; g < 16; g++) begin : g_block
    assign core_block[511-32*g -: 32] = r_msg[g];
  end

  assign core_start = r_core_start;
  assign core_init  = r_init;

  assign w_unused = &{1'b0, RESP_OKAY, w_rd_en, w_wr_addr[1:0], w_rd_addr[1:0]};

endmodule

// File: tb/tb_sha256_axil_slave.sv
// Directed self-checking bench for sha256_axil_slave; also covers SHA256_AXIL_IRQ_EN when defined.
`timescale 1ns/1ps
module tb_sha256_axil_slave;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [31:0]  awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [3:0]   wstrb = '0;
  logic [2:0]   awprot = '0, arprot = '0;
  logic         core_start, core_init;
  logic [511:0] core_block;
  logic         core_busy = 1'b0, core_digest_valid = 1'b0;
  logic [255:0] core_digest = '0;
`ifdef SHA256_AXIL_IRQ_EN
  logic         irq;
`endif

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  logic        cap_init;
  logic [31:0] cap_w0, cap_w15;
  logic [31:0] rd;

  localparam logic [255:0] ABC_DIGEST =
    256'hBA7816BF_8F01CFEA_414140DE_5DAE2223_B00361A3_96177A9C_B410FF61_F20015AD;

  always #5 clk = ~clk;

  sha256_axil_slave dut (
    .clk               (clk),
    .resetn            (resetn),
    .mem_axi_awvalid   (awvalid),
    .mem_axi_awready   (awready),
    .mem_axi_awaddr    (awaddr),
    .mem_axi_awprot    (awprot),
    .mem_axi_wvalid    (wvalid),
    .mem_axi_wready    (wready),
    .mem_axi_wdata     (wdata),
    .mem_axi_wstrb     (wstrb),
    .mem_axi_bvalid    (bvalid),
    .mem_axi_bready    (bready),
    .mem_axi_arvalid   (arvalid),
    .mem_axi_arready   (arready),
    .mem_axi_araddr    (araddr),
    .mem_axi_arprot    (arprot),
    .mem_axi_rvalid    (rvalid),
    .mem_axi_rready    (rready),
    .mem_axi_rdata     (rdata),
    .core_start        (core_start),
    .core_init         (core_init),
    .core_block        (core_block),
    .core_busy         (core_busy),
    .core_digest_valid (core_digest_valid),
`ifdef SHA256_AXIL_IRQ_EN
    .irq               (irq),
`endif
    .core_digest       (core_digest)
  );

  // Records every start pulse and what the core would latch with it.
  always @(posedge clk) begin
    if (resetn && core_start) begin
      start_cnt <= start_cnt + 1;
      cap_init  <= core_init;
      cap_w0    <= core_block[511:480];
      cap_w15   <= core_block[31:0];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead);
    bit aw_pend = 1'b1, w_pend = 1'b1, aw_hs, w_hs;
    int cyc = 0;
    @(posedge clk); #1;
    awaddr = addr; wdata = data; wstrb = strb;
    wvalid = 1'b1; awvalid = (w_lead == 0);
    while ((aw_pend || w_pend) && cyc < 50) begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) begin awvalid = 1'b0; aw_pend = 1'b0; end
      if (w_hs)  begin wvalid = 1'b0;  w_pend = 1'b0;  end
      cyc++;
      if (aw_pend && cyc >= w_lead) awvalid = 1'b1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    bready = 1'b1;
    cyc = 0;
    while (cyc < 50) begin
      @(negedge clk);
      if (bvalid) break;
      cyc++;
    end
    check("wr_bvalid", {31'd0, bvalid}, 32'd1);
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    check("wr_bvalid_single", {31'd0, bvalid}, 32'd0);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, input int stall);
    int cyc = 0;
    logic [31:0] first;
    @(posedge clk); #1;
    araddr = addr; arvalid = 1'b1;
    while (cyc < 50) begin
      @(negedge clk);
      if (arready) break;
      cyc++;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    cyc = 0;
    while (cyc < 50) begin
      @(negedge clk);
      if (rvalid) break;
      cyc++;
    end
    check("rd_rvalid", {31'd0, rvalid}, 32'd1);
    first = rdata;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("rd_stable", rdata, first);
      check("rd_arready_low", {31'd0, arready}, 32'd0);
      check("rd_rvalid_held", {31'd0, rvalid}, 32'd1);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    data = first;
  endtask

  initial begin
    // Reset
    repeat (5) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    check("rst_awready", {31'd0, awready}, 32'd1);
    check("rst_wready",  {31'd0, wready},  32'd1);
    check("rst_arready", {31'd0, arready}, 32'd1);
    check("rst_bvalid",  {31'd0, bvalid},  32'd0);
    check("rst_rvalid",  {31'd0, rvalid},  32'd0);
    check("rst_rdata",   rdata,            32'd0);
    check("rst_core_start", {31'd0, core_start}, 32'd0);
    axi_read(32'h04, rd, 0);
    check("rst_status", rd, 32'h0);

    // Split handshake: W leads AW by three cycles
    axi_write(32'h40, 32'h12345678, 4'hF, 3);
    axi_read(32'h40, rd, 0);
    check("split_msg0", rd, 32'h12345678);

    // Byte strobes
    axi_write(32'h44, 32'hAABBCCDD, 4'b0010, 0);
    axi_read(32'h44, rd, 0);
    check("strb_msg1", rd, 32'h0000CC00);

    // "abc" block
    axi_write(32'h40, 32'h61626380, 4'hF, 0);
    for (int i = 1; i < 15; i++) axi_write(32'h40 + 32'(4 * i), 32'h0, 4'hF, 0);
    axi_write(32'h7C, 32'h00000018, 4'hF, 0);
    axi_read(32'h7C, rd, 0);
    check("msg15", rd, 32'h00000018);
    axi_write(32'h00, 32'h3, 4'h1, 0);
    repeat (3) @(negedge clk);
    check("abc_start_cnt", 32'(start_cnt), 32'd1);
    check("abc_init", {31'd0, cap_init}, 32'd1);
    check("abc_block_w0", cap_w0, 32'h61626380);
    check("abc_block_w15", cap_w15, 32'h00000018);
    @(posedge clk); #1 core_busy = 1'b1;
    repeat (4) @(posedge clk);
    #1 core_busy = 1'b0; core_digest_valid = 1'b1; core_digest = ABC_DIGEST;
    @(posedge clk); #1 core_digest_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abc_start_single", 32'(start_cnt), 32'd1);
    axi_read(32'h80, rd, 0);
    check("digest0", rd, 32'hBA7816BF);
    axi_read(32'h9C, rd, 0);
    check("digest7", rd, 32'hF20015AD);
    axi_read(32'h8C, rd, 0);
    check("digest3", rd, 32'h5DAE2223);
    axi_read(32'h04, rd, 0);
    check("status_done", rd, 32'h2);
    axi_read(32'h00, rd, 0);
    check("ctrl_init_rd", rd, 32'h2);

    // Busy guard
    @(posedge clk); #1 core_busy = 1'b1;
    axi_write(32'h00, 32'h1, 4'h1, 0);
    axi_write(32'h40, 32'hFFFFFFFF, 4'hF, 0);
    repeat (3) @(negedge clk);
    check("busy_no_start", 32'(start_cnt), 32'd1);
    axi_read(32'h40, rd, 0);
    check("busy_msg0_kept", rd, 32'h61626380);
    axi_read(32'h04, rd, 0);
    check("busy_status", rd, 32'h3);
    axi_read(32'h00, rd, 0);
    check("busy_init_upd", rd, 32'h0);
    @(posedge clk); #1 core_busy = 1'b0;

    // Backpressure on a digest read
    axi_read(32'h80, rd, 4);
    check("bp_digest0", rd, 32'hBA7816BF);

    // Read-only and unmapped offsets, CTRL byte-lane gating
    axi_write(32'h80, 32'h0, 4'hF, 0);
    axi_read(32'h80, rd, 0);
    check("digest_ro", rd, 32'hBA7816BF);
    axi_write(32'h08, 32'hFFFFFFFF, 4'hF, 0);
    axi_read(32'h08, rd, 0);
    check("unmapped_08", rd, 32'h0);
    axi_read(32'hA0, rd, 0);
    check("unmapped_a0", rd, 32'h0);
    axi_write(32'h00, 32'h3, 4'b1110, 0);
    repeat (3) @(negedge clk);
    check("ctrl_strb_no_start", 32'(start_cnt), 32'd1);
    axi_read(32'h00, rd, 0);
    check("ctrl_strb_no_init", rd, 32'h0);

    // A second start clears done and carries INIT
    axi_write(32'h00, 32'h3, 4'h1, 0);
    repeat (3) @(negedge clk);
    check("restart_cnt", 32'(start_cnt), 32'd2);
    check("restart_init", {31'd0, cap_init}, 32'd1);
    axi_read(32'h04, rd, 0);
    check("restart_done_clr", rd, 32'h0);
    @(posedge clk); #1 core_busy = 1'b1;
    @(posedge clk); #1 core_busy = 1'b0;

`ifdef SHA256_AXIL_IRQ_EN
    axi_write(32'h00, 32'h4, 4'h1, 0);
    axi_read(32'h00, rd, 0);
    check("ie_rd", rd, 32'h4);
    @(negedge clk);
    check("irq_idle", {31'd0, irq}, 32'd0);
    @(posedge clk); #1 core_digest_valid = 1'b1;
    @(posedge clk); #1 core_digest_valid = 1'b0;
    @(negedge clk);
    check("irq_lat0", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("irq_lat1", {31'd0, irq}, 32'd1);
    axi_write(32'h00, 32'h0, 4'h1, 0);
    repeat (2) @(negedge clk);
    check("irq_cleared", {31'd0, irq}, 32'd0);
`else
    axi_write(32'h00, 32'h4, 4'h1, 0);
    axi_read(32'h00, rd, 0);
    check("ie_absent", rd, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sha256_axil_slave.md
Name: sha256_axil_slave

Overview:
- Synthesizable AXI4-lite responder that gives the picorv32_axi firmware register access to the SHA-256 core.
- Exposes control/status, a 16-word message block buffer and an 8-word digest readback.
- Drives a simple start/busy/digest-valid handshake into the unrolled SHA core.
- Replaces the behavioural memory peripheral for accelerator address space on the CPU AXI4-lite bus.

Parameters:
- ADDR_LSB_W, 8, number of low address bits decoded; upper bits ignored (base decode done outside).
- RESP_OKAY, 2'b00, response code returned on every transaction.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- mem_axi_awvalid/awready  in/out  1/1  write address handshake
- mem_axi_awaddr  in  32  write address
- mem_axi_awprot  in  3  ignored
- mem_axi_wvalid/wready  in/out  1/1  write data handshake
- mem_axi_wdata  in  32  write data
- mem_axi_wstrb  in  4  byte enables
- mem_axi_bvalid/bready  out/in  1/1  write response handshake (response is always OKAY)
- mem_axi_arvalid/arready  in/out  1/1  read address handshake
- mem_axi_araddr  in  32  read address
- mem_axi_arprot  in  3  ignored
- mem_axi_rvalid/rready  out/in  1/1  read data handshake
- mem_axi_rdata  out  32  read data
- core_start  out  1  one-cycle start pulse to SHA core
- core_init  out  1  1 = first block (load IV); 0 = continue from prior digest
- core_block  out  512  message block; word0 at [511:480]
- core_busy  in  1  core processing
- core_digest_valid  in  1  one-cycle pulse, digest ready
- core_digest  in  256  H0 at [255:224]

Behaviour:
- One clock; reset is synchronous and active-low.
- Reset values:
  - awready, wready, arready = 1.
  - bvalid, rvalid, core_start = 0; rdata = 0.
  - MSG, DIGEST, CTRL.init and STATUS.done = 0.
- Register map (byte offsets):
  - 0x00 CTRL: bit0 START (write-1 pulses, reads 0), bit1 INIT (R/W).
  - 0x04 STATUS RO: bit0 busy = core_busy, bit1 done (sticky).
  - 0x40-0x7C MSG[0..15] R/W.
  - 0x80-0x9C DIGEST[0..7] RO.
  - All other offsets read 0; writes to them are ignored.
- Write FSM, states W_IDLE, W_WAIT, W_RESP:
  - AW and W are accepted independently; each ready drops after its beat is captured.
  - When both are held, the register update occurs that cycle and the FSM enters W_RESP with bvalid=1 on the next cycle.
  - bvalid is held until bready; then awready and wready return to 1 and the FSM enters W_IDLE.
  - One outstanding write.
- Read FSM, states R_IDLE, R_DATA:
  - AR is accepted when arready=1; rdata is registered from current state and rvalid=1 the next cycle.
  - rvalid and rdata are held stable until rready; arready=0 while in R_DATA.
- Read and write proceed concurrently.
- A read in the same cycle as a register update returns the pre-update value.
- wstrb: MSG honours per-byte enables. CTRL acts only when wstrb[0]=1.
- START (CTRL write, wdata[0]=1):
  - If core_busy=0 and no start is pending: core_start=1 for exactly one cycle after the write-commit cycle.
  - core_init = wdata[1] written in the same write. done is cleared.
  - If core_busy=1: START is ignored; INIT is still updated.
- MSG writes while core_busy=1 are ignored; response is still OKAY.
- core_digest_valid captures core_digest into DIGEST[0..7] and sets done.
- A done-set in the same cycle as a START clear resolves to done=1.
- core_block = MSG concatenation, held stable while busy.
- Reset mid-transaction drops bvalid/rvalid without a response; the master is reset together with this block.

Optional Feature:
- Macro: SHA256_AXIL_IRQ_EN.
- Defined:
  - Adds output irq (1 bit).
  - Adds CTRL bit2 IE (R/W, reset 0).
  - irq = done & IE, registered, 1-cycle latency.
  - Firmware clears irq by writing START or clearing IE.
- Undefined: no irq port; CTRL bit2 reads 0 and writes to it are ignored.

Decomposition:
- Shared package sha256_axil_pkg:
  - Register offset constants (CTRL, STATUS, MSG_BASE, DIGEST_BASE).
  - CTRL/STATUS bit index constants.
  - Write-FSM and read-FSM state typedefs.
- One natural sub-module: sha256_axil_if, the AXI4-lite channel handshake engine.
  - Outputs wr_en, wr_addr, wr_data, wr_strb, rd_en, rd_addr.
  - Input rd_data.
- The top level holds the register file and core handshake.

Test Plan:
- Reset: hold resetn=0 for 5 cycles, then release -> ready signals = 1, bvalid/rvalid = 0, read of 0x04 returns 0x0.
- Split handshake: present W (0x12345678 to 0x40) 3 cycles before AW -> one bvalid, read 0x40 returns 0x12345678.
- Byte strobes: wstrb=4'b0010, wdata=0xAABBCCDD to 0x44 -> read returns 0x0000CC00.
- "abc" block:
  - Write MSG0=0x61626380, MSG1-14=0, MSG15=0x00000018, then CTRL=0x3.
  - Expect a single core_start pulse with core_init=1 and core_block[511:480]=0x61626380.
  - Core model returns the digest -> read 0x80 = 0xBA7816BF, 0x9C = 0xF20015AD, STATUS = 0x2.
- Busy guard: with core_busy=1, write CTRL=0x1 and MSG0=0xFFFFFFFF -> no core_start pulse, MSG0 unchanged.
- Backpressure: hold rready=0 for 4 cycles on a read of 0x80 -> rdata stable throughout, arready=0 until the beat completes. With SHA256_AXIL_IRQ_EN defined and IE=1, irq rises 1 cycle after done.
